mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Arbitrates the single-port data memory / device bus between two masters.
- Master 0 is the CPU MEM stage (PrAddr/PrWD/PrWe side). It has default priority and zero added latency.
- Master 1 is a DMA/loader engine that issues word bursts through a req/gnt handshake.
- A wait counter guarantees DMA forward progress; the CPU is frozen via cpu_stall while a burst owns the bus.
- Sits between the CPU, the dm/device bridge and the DMA engine.

Parameters:
MAX_WAIT, 4, consecutive contended IDLE cycles DMA may be denied before a forced grant (range 1..15).
BURST_MAX, 8, maximum beats per burst (range 1..15).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU MEM-stage access valid (load or store)
cpu_we  in  1  CPU store
cpu_addr  in  32  CPU byte address
cpu_wd  in  32  CPU store data
cpu_rd  out  32  read data to CPU
cpu_stall  out  1  freezes CPU pipeline; CPU holds cpu_* stable while high
dma_req  in  1  DMA burst request
dma_we  in  1  burst direction, 1 = write
dma_addr  in  32  burst base byte address
dma_len  in  4  burst length in words
dma_wd  in  32  DMA write data for current beat
dma_gnt  out  1  current beat executes this cycle
dma_rvalid  out  1  dma_rd valid this cycle
dma_rd  out  32  DMA read data
dma_done  out  1  high during last beat of a burst
bus_addr  out  32  address to memory/devices
bus_wd  out  32  write data to memory/devices
bus_we  out  1  write strobe
bus_rd  in  32  combinational read data from memory/devices

Behaviour:
States: IDLE, BURST. Registers: state, wait_cnt[3:0], beat_cnt[3:0], base[31:0], len_l[3:0], we_l.

Reset (reset low, async):
- state=IDLE; all counters and latches cleared.
- dma_gnt=0, dma_rvalid=0, dma_done=0, cpu_stall=0, bus_we=0.
- Applies immediately, including mid-burst: the burst is abandoned and no dma_done is issued.

IDLE:
- Bus mirrors CPU combinationally: bus_addr=cpu_addr, bus_wd=cpu_wd, bus_we=cpu_req&cpu_we, cpu_rd=bus_rd.
- cpu_stall=0, dma_gnt=0.
- Grant condition = dma_req & (!cpu_req | wait_cnt==MAX_WAIT).
- On grant at edge k:
  - latch base={dma_addr[31:2],2'b00}, we_l=dma_we;
  - latch len_l = 1 if dma_len==0, BURST_MAX if dma_len>BURST_MAX, else dma_len;
  - beat_cnt=0, wait_cnt=0; state=BURST from k+1.
- wait_cnt:
  - increments (saturating at MAX_WAIT) on edges where dma_req&cpu_req and no grant;
  - clears when dma_req=0.

BURST:
- Bus owned by DMA: bus_addr=base+(beat_cnt<<2), using 32-bit wrap-around add.
- bus_we=we_l, bus_wd=dma_wd.
- dma_gnt=1 every BURST cycle.
- dma_rvalid=!we_l, dma_rd=bus_rd.
- cpu_stall=cpu_req (combinational); CPU accesses are never issued to the bus in BURST.
- beat_cnt increments each edge.
- Last beat when beat_cnt==len_l-1: dma_done=1 that cycle, state=IDLE at next edge.
- dma_req and dma_addr/len/we changes are ignored during BURST.
- Back-to-back bursts are permitted: a grant may occur on the first IDLE cycle after a burst if the grant condition holds.

Timing:
- CPU access latency is 0 cycles when not stalled.
- DMA grant-to-first-beat latency is 1 cycle.
- Burst occupies exactly len_l cycles.

Test Plan:
- CPU store, no DMA: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wd=0x1234 -> same cycle bus_we=1, bus_addr=0x10, bus_wd=0x1234, cpu_stall=0.
- DMA read, CPU idle: dma_req=1, dma_addr=0x100, dma_len=3, dma_we=0 -> next 3 cycles dma_gnt=1, bus_addr=0x100/0x104/0x108, dma_rvalid=1 with dma_rd=bus_rd, dma_done only on third beat, then IDLE.
- Contention, MAX_WAIT=4: cpu_req and dma_req held high, dma_len=2 -> CPU served 5 cycles unstalled (wait_cnt 0..4), then 2 BURST cycles with cpu_stall=1, then CPU resumes.
- Length clamp: dma_len=0 -> 1 beat with dma_done; dma_len=12 -> exactly 8 beats.
- Reset mid-burst: reset low during beat 1 of a 4-beat burst -> dma_gnt, cpu_stall, bus_we drop immediately; after release state=IDLE and no dma_done ever seen.
- Wrap and alignment: dma_addr=0xFFFFFFFE, dma_len=2 -> bus_addr=0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - CPU, DMA and memory bus signals around the arbiter
// slave is the arbiter's view; master is the surrounding CPU/DMA/memory view.
interface mem_bus_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wd;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rd;
  logic        dma_done;
  logic [31:0] bus_addr;
  logic [31:0] bus_wd;
  logic        bus_we;
  logic [31:0] bus_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wd,
    input  bus_rd,
    output cpu_rd, cpu_stall,
    output dma_gnt, dma_rvalid, dma_rd, dma_done,
    output bus_addr, bus_wd, bus_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd,
    output dma_req, dma_we, dma_addr, dma_len, dma_wd,
    output bus_rd,
    input  cpu_rd, cpu_stall,
    input  dma_gnt, dma_rvalid, dma_rd, dma_done,
    input  bus_addr, bus_wd, bus_we
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter for the single-port data memory bus
// CPU has default priority with zero latency; DMA bursts get a forced grant after MAX_WAIT denials.
module mem_bus_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [31:0] base_q, base_d;
  logic [3:0]  len_l_q, len_l_d;
  logic        we_l_q, we_l_d;
  logic        grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      beat_cnt_q <= 4'd0;
      base_q     <= 32'd0;
      len_l_q    <= 4'd0;
      we_l_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      base_q     <= base_d;
      len_l_q    <= len_l_d;
      we_l_q     <= we_l_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    base_d         = base_q;
    len_l_d        = len_l_q;
    we_l_d         = we_l_q;
    grant          = 1'b0;
    bus.bus_addr   = bus.cpu_addr;
    bus.bus_wd     = bus.cpu_wd;
    // Gated by reset so a CPU store cannot strobe the bus while the block is held in reset.
    bus.bus_we     = reset & bus.cpu_req & bus.cpu_we;
    bus.cpu_rd     = bus.bus_rd;
    bus.cpu_stall  = 1'b0;
    bus.dma_gnt    = 1'b0;
    bus.dma_rvalid = 1'b0;
    bus.dma_rd     = bus.bus_rd;
    bus.dma_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant = bus.dma_req & (!bus.cpu_req | (wait_cnt_q == MAX_WAIT_C));
        if (grant) begin
          base_d     = bus.dma_addr & 32'hFFFF_FFFC;
          we_l_d     = bus.dma_we;
          if (bus.dma_len == 4'd0)
            len_l_d = 4'd1;
          else if (bus.dma_len > BURST_MAX_C)
            len_l_d = BURST_MAX_C;
          else
            len_l_d = bus.dma_len;
          beat_cnt_d = 4'd0;
          wait_cnt_d = 4'd0;
          state_d    = S_BURST;
        end else if (!bus.dma_req) begin
          wait_cnt_d = 4'd0;
        end else if (bus.cpu_req && (wait_cnt_q != MAX_WAIT_C)) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_BURST: begin
        bus.bus_addr   = base_q + {26'd0, beat_cnt_q, 2'b00};
        bus.bus_wd     = bus.dma_wd;
        bus.bus_we     = reset & we_l_q;
        bus.cpu_stall  = reset & bus.cpu_req;
        bus.dma_gnt    = reset;
        bus.dma_rvalid = reset & !we_l_q;
        beat_cnt_d     = beat_cnt_q + 4'd1;
        if (beat_cnt_q == len_l_q - 4'd1) begin
          bus.dma_done = reset;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int          MAX_WAIT  = 4;
  localparam int          BURST_MAX = 8;
  localparam logic [31:0] RD_KEY    = 32'h5A5A_C3C3;

  typedef struct {
    string       tag;
    logic        idle;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic        done;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  logic        m_burst;
  logic [3:0]  m_wait;
  logic [3:0]  m_beat;
  logic [3:0]  m_len;
  logic [31:0] m_base;
  logic        m_we;

  mem_bus_arbiter_if bif();

  mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  assign bif.bus_rd = bif.bus_addr ^ RD_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ".stall"}, 32'(bif.cpu_stall), 32'(e.stall));
      check({e.tag, ".gnt"},   32'(bif.dma_gnt),   32'(e.gnt));
      check({e.tag, ".rvalid"},32'(bif.dma_rvalid),32'(e.rvalid));
      check({e.tag, ".done"},  32'(bif.dma_done),  32'(e.done));
      check({e.tag, ".we"},    32'(bif.bus_we),    32'(e.we));
      check({e.tag, ".addr"},  bif.bus_addr,       e.addr);
      check({e.tag, ".wd"},    bif.bus_wd,         e.wd);
      if (e.rvalid) check({e.tag, ".dma_rd"}, bif.dma_rd, e.rd);
      if (e.idle)   check({e.tag, ".cpu_rd"}, bif.cpu_rd, e.rd);
    end
  end

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0) return 4'd1;
    if (int'(len) > BURST_MAX) return 4'(BURST_MAX);
    return len;
  endfunction

  // Predict this cycle's outputs, queue them, advance the model across the next edge.
  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    if (!m_burst) begin
      e.idle = 1'b1; e.stall = 1'b0; e.gnt = 1'b0; e.rvalid = 1'b0; e.done = 1'b0;
      e.we   = bif.cpu_req & bif.cpu_we;
      e.addr = bif.cpu_addr;
      e.wd   = bif.cpu_wd;
    end else begin
      e.idle = 1'b0; e.stall = bif.cpu_req; e.gnt = 1'b1; e.rvalid = !m_we;
      e.done = (int'(m_beat) == int'(m_len) - 1);
      e.we   = m_we;
      e.addr = m_base + 32'(int'(m_beat) * 4);
      e.wd   = bif.dma_wd;
    end
    e.rd = e.addr ^ RD_KEY;
    sb_q.push_back(e);

    if (!m_burst) begin
      if (bif.dma_req && (!bif.cpu_req || int'(m_wait) == MAX_WAIT)) begin
        m_burst = 1'b1;
        m_base  = {bif.dma_addr[31:2], 2'b00};
        m_we    = bif.dma_we;
        m_len   = clamp_len(bif.dma_len);
        m_beat  = 4'd0;
        m_wait  = 4'd0;
      end else if (!bif.dma_req) begin
        m_wait = 4'd0;
      end else if (bif.cpu_req && int'(m_wait) < MAX_WAIT) begin
        m_wait = m_wait + 4'd1;
      end
    end else begin
      if (int'(m_beat) == int'(m_len) - 1) m_burst = 1'b0;
      m_beat = m_beat + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_burst = 1'b0; m_wait = 4'd0; m_beat = 4'd0; m_len = 4'd0; m_base = 32'd0; m_we = 1'b0;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr, input logic [3:0] len);
    bif.dma_req = req; bif.dma_we = we; bif.dma_addr = addr; bif.dma_len = len;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bif.cpu_req = req; bif.cpu_we = we; bif.cpu_addr = addr; bif.cpu_wd = wd;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 4'd0);
    bif.dma_wd = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt",    32'(bif.dma_gnt),    32'd0);
    check("rst.rvalid", 32'(bif.dma_rvalid), 32'd0);
    check("rst.done",   32'(bif.dma_done),   32'd0);
    check("rst.stall",  32'(bif.cpu_stall),  32'd0);
    check("rst.we",     32'(bif.bus_we),     32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // CPU-only accesses
    set_cpu(1'b1, 1'b1, 32'h10, 32'h1234);
    step("cpu_st");
    set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
    step("cpu_ld");

    // DMA read burst with the CPU idle; request lines change mid-burst and must be ignored
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 32'h100, 4'd3);
    step("dr_gnt");
    set_dma(1'b0, 1'b1, 32'h999, 4'd7);
    repeat (3) step("dr_beat");
    step("dr_idle");

    // Contention: five unstalled CPU cycles, two stalled burst beats, CPU resumes
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dma(1'b1, 1'b1, 32'h200, 4'd2);
    bif.dma_wd = 32'hCAFE_0001;
    repeat (9) step("cont");
    set_dma(1'b0, 1'b0, 32'h0, 4'd0);
    step("cont_end");

    // Length clamp: zero length back-to-back, then over-long
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 32'h300, 4'd0);
    repeat (4) step("len0");
    set_dma(1'b1, 1'b1, 32'h400, 4'd12);
    step("len12_gnt");
    set_dma(1'b0, 1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 9; i++) begin
      bif.dma_wd = 32'hD000_0000 + 32'(i);
      step("len12");
    end

    // Address alignment and 32-bit wrap-around
    set_dma(1'b1, 1'b0, 32'hFFFF_FFFE, 4'd2);
    step("wrap_gnt");
    set_dma(1'b0, 1'b0, 32'h0, 4'd0);
    repeat (3) step("wrap");

    // Reset during beat 1 of a 4-beat write burst
    set_dma(1'b1, 1'b1, 32'h500, 4'd4);
    step("mrst_gnt");
    set_dma(1'b0, 1'b0, 32'h0, 4'd0);
    step("mrst_b0");
    set_cpu(1'b1, 1'b1, 32'h80, 32'h55);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("mrst.gnt",   32'(bif.dma_gnt),   32'd0);
    check("mrst.stall", 32'(bif.cpu_stall), 32'd0);
    check("mrst.we",    32'(bif.bus_we),    32'd0);
    check("mrst.done",  32'(bif.dma_done),  32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step("mrst_idle");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      set_dma(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      bif.dma_wd = $urandom;
      step("rand");
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 4'd0);
    repeat (BURST_MAX + 1) step("drain");

    @(negedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
